// File: rtl/serial_adder_ctrl_pkg.sv
// Purpose: shared constants for the bit-serial add/subtract controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Purpose: start/done handshake bundle between a requester and the serial adder.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the adder is idle, never queued.
// Signals: start, sub, a, b, cin (requester -> adder); busy, done, sum, cout, ovf (adder -> requester).
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// Purpose: single gate-level full-adder cell, the per-bit datapath of the serial adder.
// Latency: combinational.
// Backpressure: n/a.
// Ports: i_a, i_b, i_c (addends and carry-in); o_s (sum bit), o_co (carry-out).
module serial_adder_ctrl_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);
    logic w_axb;

    assign w_axb = i_a ^ i_b;
    assign o_s   = w_axb ^ i_c;
    assign o_co  = (i_a & i_b) | (w_axb & i_c);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Purpose: bit-serial add/subtract of two WIDTH-bit operands through one full adder.
// Latency: done pulses WIDTH+1 cycles after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: start is ignored (not queued) while busy; operands are captured at acceptance.
// Ports: clk, rst_n (sync, active-low), bus (slave side of serial_adder_ctrl_if).
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    // Holds the WIDTH-1 sum bits produced so far; the MSB bit joins it on the last edge.
    logic [WIDTH-2:0]   r_res;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_shift;

    serial_adder_ctrl_fa u_fa (
        .i_a  (r_op_a[0]),
        .i_b  (r_op_b[0]),
        .i_c  (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // New sum bit enters from the MSB side; on the MSB edge this is the full result.
    assign w_shift = {w_s, r_res};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        // Subtract as a + ~b + 1: invert B and force the carry-in.
                        r_op_a  <= bus.a;
                        r_op_b  <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub ? 1'b1 : bus.cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_res   <= w_shift[WIDTH-1:1];
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_shift;
                        r_cout  <= w_co;
                        // r_carry is the carry into the MSB at this point.
                        r_ovf   <= r_carry ^ w_co;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_done = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic from plain integer rules.
    function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c,
                                 output logic [W-1:0] r, output logic co, output logic ov);
        longint ua, ub, sa, sb, tot, st;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb = b[W-1] ? ub - (longint'(1) << W) : ub;
        if (s) begin
            tot = ua - ub + (longint'(1) << W);
            co  = (ua >= ub);
            st  = sa - sb;
        end else begin
            tot = ua + ub + longint'(c);
            co  = (tot >= (longint'(1) << W));
            st  = sa + sb + longint'(c);
        end
        r  = tot[W-1:0];
        ov = (st > (longint'(1) << (W-1)) - 1) || (st < -(longint'(1) << (W-1)));
    endfunction

    // Timeline model: an accepted op at edge acc is busy through edge acc+W,
    // reports at edge acc+W, and the next accept is possible at edge acc+W+2.
    int         cyc = 0;
    int         acc = -1000;
    bit         chk_en = 0;
    logic [W-1:0] p_sum, e_sum;
    logic       p_cout, p_ovf, e_cout, e_ovf, e_busy, e_done;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            acc    = -1000;
            e_sum  = '0;
            e_cout = 1'b0;
            e_ovf  = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (cyc >= acc + W + 2 && bus.start === 1'b1) begin
                acc = cyc;
                calc(bus.a, bus.b, bus.sub, bus.cin, p_sum, p_cout, p_ovf);
            end
            if (cyc == acc + W) begin
                e_sum  = p_sum;
                e_cout = p_cout;
                e_ovf  = p_ovf;
            end
        end
        e_busy = (cyc >= acc) && (cyc <= acc + W);
        e_done = (cyc == acc + W);
    end

    task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic c,
                      input logic [W-1:0] xs, input logic xc, input logic xo);
        int k, nb;
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = s; bus.cin = c;
        @(negedge clk);
        // Post-acceptance operand changes must not matter.
        bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.sub = ~s; bus.cin = ~c;
        k  = 1;
        nb = int'(bus.busy);
        while (bus.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            nb += int'(bus.busy);
        end
        check({nm, "_latency"}, k, W + 1);
        check({nm, "_busy_cycles"}, nb, W + 1);
        check({nm, "_sum"}, bus.sum, xs);
        check({nm, "_cout"}, bus.cout, xc);
        check({nm, "_ovf"}, bus.ovf, xo);
        @(negedge clk);
        check({nm, "_busy_after"}, {bus.busy, bus.done}, 2'b00);
    endtask

    logic [W-1:0] b2b_a [3] = '{8'h01, 8'h40, 8'hF0};
    logic [W-1:0] b2b_b [3] = '{8'h01, 8'h40, 8'h20};
    logic [W-1:0] b2b_s [3] = '{8'h02, 8'h80, 8'h10};
    logic         b2b_o [3] = '{1'b0, 1'b1, 1'b0};
    logic         b2b_c [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int d0, idx, last;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        fork
            begin : cmp
                forever begin
                    @(negedge clk);
                    if (chk_en) begin
                        check("cycle_outputs", {bus.busy, bus.done, bus.cout, bus.ovf, bus.sum},
                              {e_busy, e_done, e_cout, e_ovf, e_sum});
                        if (bus.done === 1'b1) n_done++;
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.busy, bus.done, bus.cout, bus.ovf, bus.sum}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        op("add_5a_3c",    8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        op("add_ff_01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op("add_ff_00_ci", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        op("sub_10_20",    8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        op("sub_80_01",    8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Second start 3 cycles into RUN is ignored.
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        d0 = n_done;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.sub = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("restart_done_count", n_done - d0, 1);
        check("restart_sum", {bus.cout, bus.ovf, bus.sum}, {2'b00, 8'h33});

        // Reset after bits 0..3 have been processed.
        bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h3C; bus.sub = 1'b0; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        d0 = n_done;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_reset_busy", bus.busy, 1'b0);
        check("midrun_reset_sum", bus.sum, 8'h00);
        repeat (12) @(negedge clk);
        check("midrun_reset_no_done", n_done - d0, 0);
        op("after_reset", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Start held high: accept every W+2 cycles.
        idx = 0;
        last = 0;
        bus.start = 1'b1; bus.a = b2b_a[0]; bus.b = b2b_b[0]; bus.sub = 1'b0; bus.cin = 1'b0;
        for (int i = 0; i < 80 && idx < 3; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                check("b2b_sum", {bus.cout, bus.ovf, bus.sum}, {b2b_c[idx], b2b_o[idx], b2b_s[idx]});
                if (idx > 0) check("b2b_spacing", i - last, W + 2);
                last = i;
                idx++;
                if (idx < 3) begin
                    bus.a = b2b_a[idx];
                    bus.b = b2b_b[idx];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        check("b2b_count", idx, 3);
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("b2b_idle", bus.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller built around a single full-adder cell. It accepts two WIDTH-bit operands on a start strobe, streams them LSB-first through the one full adder over WIDTH cycles using a carry flip-flop, and returns the registered sum, carry-out and signed overflow with a done pulse. It is the area-minimal alternative to the ripple-carry adders in the arithmetic lab blocks and is driven by a simple start/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored)
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
cin  input  1  carry-in for add, sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when the result is valid
sum  output  WIDTH  result, held until the next accepted start
cout  output  1  carry-out (for sub: 1 = no borrow)
ovf  output  1  signed overflow

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy, done, sum, cout, ovf, bit counter, carry FF and shift registers = 0. Reset mid-RUN aborts the operation with no done pulse.
- States: IDLE -> RUN on start=1. RUN -> DONE after WIDTH bit-cycles. DONE -> IDLE unconditionally after 1 cycle.
- Accept (edge E0 in IDLE with start=1):
  - load op_a=a; op_b = sub ? ~b : b.
  - carry FF = sub ? 1 : cin.
  - bit counter = 0.
- RUN, each edge:
  - full adder inputs are op_a[0], op_b[0] and the carry FF.
  - the sum bit shifts into the result shift register from the MSB side.
  - op_a and op_b shift right by one; carry FF takes the adder carry-out.
  - counter increments.
  - on the edge where counter = WIDTH-1 (the MSB bit), capture the carry into the MSB. That edge also loads the outputs:
    - sum = final shifted result
    - cout = MSB carry-out
    - ovf = MSB carry-in XOR MSB carry-out
    - state -> DONE.
- Latency: start sampled at E0; done=1 in the cycle following edge E(WIDTH), i.e. WIDTH+1 cycles after the start edge. Throughput is one operation per WIDTH+2 cycles.
- sum, cout and ovf change only at the MSB edge of an accepted operation. They stay stable while busy and after done, until the next result.
- start while busy (RUN or DONE) is ignored and not queued. Changes to a, b, sub or cin after acceptance have no effect.
- done is high for exactly one cycle, coincident with state DONE. busy deasserts in the cycle after done.
- Arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits and wraps only by returning to IDLE; there is no free-running wrap.
- Operands of all-zero or all-one values need no special handling.

Decomposition:
- Shared package (arith_pkg): state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, plus the default width constant.
- One sub-module: a single instance of the team's existing FullAdder gate-level cell, used as the per-bit datapath.
- The FSM, counter, carry FF and shift registers live in serial_adder_ctrl.

Test Plan:
- WIDTH=8, add 8'h5A + 8'h3C, cin=0: done 9 cycles after the start edge with sum=8'h96, cout=0, ovf=1; busy high for 9 cycles.
- Add 8'hFF + 8'h01, cin=0: sum=8'h00, cout=1, ovf=0. Repeat with cin=1 and 8'hFF+8'h00: sum=8'h00, cout=1.
- Subtract 8'h10 - 8'h20 (sub=1, cin=1 ignored): sum=8'hF0, cout=0, ovf=0. Then 8'h80 - 8'h01: sum=8'h7F, cout=1, ovf=1.
- Pulse start again 3 cycles into RUN with different operands: no restart; the original result is reported; exactly one done pulse.
- Drive rst_n=0 for 1 cycle mid-RUN (bit 4): next cycle busy=0, sum=0, no done pulse. A fresh start then completes normally.
- Back-to-back: hold start=1 continuously. Operations are accepted every WIDTH+2 cycles; each done is one cycle wide; sum holds between results.
